data_table_rd_port: RTL and testbench

//  Responder side of the data-table read interface (rd_avail/rd_en/rd_addr -> rd_data/rd_data_val).

---
 rtl/data_table_rd_port.sv | 108 ++++++++++
 tb/tb_data_table_rd_port.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_table_rd_port.sv
// Data-table read port: round-robin arbitration of several engines onto one
// fixed-latency RAM read port, with a tag pipe that routes each returning
// word back to the engine that asked for it.
module data_table_rd_port #(
  parameter int CLIENTS_CNT = 3,
  parameter int A_WIDTH     = 8,
  parameter int RAM_LATENCY = 2,
  parameter int DATA_W      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [CLIENTS_CNT-1:0]         rd_en_i,
  input  logic [CLIENTS_CNT*A_WIDTH-1:0] rd_addr_i,
  output logic [CLIENTS_CNT-1:0]         rd_avail_o,
  output logic [DATA_W-1:0]              rd_data_o,
  output logic [CLIENTS_CNT-1:0]         rd_data_val_o,
  output logic                           ram_rd_en_o,
  output logic [A_WIDTH-1:0]             ram_rd_addr_o,
  input  logic [DATA_W-1:0]              ram_rd_data_i
);

  localparam int IDX_W = (CLIENTS_CNT > 1) ? $clog2(CLIENTS_CNT) : 1;

  logic [CLIENTS_CNT-1:0] busy;
  logic [IDX_W-1:0]       last_gnt;
  logic [CLIENTS_CNT-1:0] req;
  logic                   gnt_vld;
  logic [IDX_W-1:0]       gnt_idx;
  logic [IDX_W-1:0]       scan_idx;
  logic [CLIENTS_CNT-1:0] gnt_oh;

  // Tag pipe: stage s holds the requester of the read issued s+1 cycles ago.
  logic [RAM_LATENCY-1:0] tag_vld_p;
  logic [IDX_W-1:0]       tag_idx_p [RAM_LATENCY];

  // A client can only issue when it has nothing outstanding; busy requests are ignored.
  assign rd_avail_o = ~busy & {CLIENTS_CNT{~rst_i}};
  assign req        = rd_en_i & rd_avail_o;

  // Round-robin scan starting just after the last granted client.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 1; k <= CLIENTS_CNT; k++) begin
      scan_idx = IDX_W'((int'(last_gnt) + k) % CLIENTS_CNT);
      if (!gnt_vld && req[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  // Stage p0: grant drives the RAM port directly in the request cycle.
  assign ram_rd_en_o   = gnt_vld;
  assign ram_rd_addr_o = gnt_vld ? rd_addr_i[gnt_idx*A_WIDTH +: A_WIDTH] : '0;

  // One-hot views of the current grant and the current return.
  always_comb begin
    gnt_oh        = '0;
    rd_data_val_o = '0;
    for (int i = 0; i < CLIENTS_CNT; i++) begin
      gnt_oh[i]        = gnt_vld && (gnt_idx == IDX_W'(i));
      rd_data_val_o[i] = tag_vld_p[RAM_LATENCY-1] && !rst_i &&
                         (tag_idx_p[RAM_LATENCY-1] == IDX_W'(i));
    end
  end

  // RAM output is broadcast unregistered; only the strobe identifies the owner.
  assign rd_data_o = ram_rd_data_i;

  // Control state: busy flags and round-robin pointer; reset drops in-flight reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy     <= '0;
      last_gnt <= IDX_W'(CLIENTS_CNT - 1);
    end else begin
      busy <= (busy & ~rd_data_val_o) | gnt_oh;
      if (gnt_vld) last_gnt <= gnt_idx;
    end
  end

  // Stage p1..pN boundary: tag valids shift every cycle and are cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_vld_p <= '0;
    end else begin
      tag_vld_p[0] <= gnt_vld;
      for (int s = 1; s < RAM_LATENCY; s++) tag_vld_p[s] <= tag_vld_p[s-1];
    end
  end

  // Tag indices travel with their valids; meaningless when the valid is low.
  always_ff @(posedge clk_i) begin
    tag_idx_p[0] <= gnt_idx;
    for (int s = 1; s < RAM_LATENCY; s++) tag_idx_p[s] <= tag_idx_p[s-1];
  end

`ifndef SYNTHESIS
  a_val_onehot0: assert property (@(posedge clk_i) $onehot0(rd_data_val_o));

  for (genvar i = 0; i < CLIENTS_CNT; i++) begin : g_addr_chk
    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      busy[i] |-> $stable(rd_addr_i[i*A_WIDTH +: A_WIDTH]));
  end
`endif

endmodule

// File: tb/tb_data_table_rd_port.sv
// Directed bench for data_table_rd_port: a latency-2 instance for the main
// scenarios and a latency-1 instance for the short-pipe case.
module tb_data_table_rd_port;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rd_en, rd_en2;
  logic [23:0] rd_addr, rd_addr2;
  logic [2:0]  rd_avail, rd_avail2;
  logic [31:0] rd_data, rd_data2;
  logic [2:0]  rd_val, rd_val2;
  logic        ram_en, ram_en2;
  logic [7:0]  ram_addr, ram_addr2;
  logic [31:0] ram_p1, ram_p2, ram2_p1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_table_rd_port #(.CLIENTS_CNT(3), .A_WIDTH(8), .RAM_LATENCY(2), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_avail_o(rd_avail), .rd_data_o(rd_data), .rd_data_val_o(rd_val),
    .ram_rd_en_o(ram_en), .ram_rd_addr_o(ram_addr), .ram_rd_data_i(ram_p2));

  data_table_rd_port #(.CLIENTS_CNT(3), .A_WIDTH(8), .RAM_LATENCY(1), .DATA_W(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en2), .rd_addr_i(rd_addr2),
    .rd_avail_o(rd_avail2), .rd_data_o(rd_data2), .rd_data_val_o(rd_val2),
    .ram_rd_en_o(ram_en2), .ram_rd_addr_o(ram_addr2), .ram_rd_data_i(ram2_p1));

  // RAM models: mem[a] = a*16, fixed read latency 2 and 1.
  always @(posedge clk) begin
    ram_p1  <= 32'(ram_addr) * 32'd16;
    ram_p2  <= ram_p1;
    ram2_p1 <= 32'(ram_addr2) * 32'd16;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rd_en = '0; rd_addr = '0; rd_en2 = '0; rd_addr2 = '0;
    nxt(); nxt();
    mid();
    chk("rst_avail", 32'(rd_avail), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_val", 32'(rd_val), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    nxt();

    // Test 1: single read by client 0, address 5.
    rst = 1'b0; rd_en = 3'b001; rd_addr = {8'd0, 8'd0, 8'd5};
    mid();
    chk("t1_c0_ram_en", 32'(ram_en), 32'd1);
    chk("t1_c0_ram_addr", 32'(ram_addr), 32'd5);
    chk("t1_c0_avail", 32'(rd_avail), 32'b111);
    nxt(); rd_en = 3'b000;
    mid();
    chk("t1_c1_avail", 32'(rd_avail), 32'b110);
    chk("t1_c1_val", 32'(rd_val), 32'd0);
    nxt();
    mid();
    chk("t1_c2_val", 32'(rd_val), 32'b001);
    chk("t1_c2_data", rd_data, 32'd80);
    chk("t1_c2_avail", 32'(rd_avail), 32'b110);
    nxt();
    mid();
    chk("t1_c3_avail", 32'(rd_avail), 32'b111);
    chk("t1_c3_val", 32'(rd_val), 32'd0);
    nxt();

    // Reset pulse so client 0 is first again.
    rst = 1'b1;
    mid();
    chk("rst2_avail", 32'(rd_avail), 32'd0);
    nxt(); rst = 1'b0;

    // Test 2: all three request together, addresses 1,2,3.
    rd_en = 3'b111; rd_addr = {8'd3, 8'd2, 8'd1};
    mid();
    chk("t2_c0_ram_addr", 32'(ram_addr), 32'd1);
    nxt(); rd_en = 3'b110;
    mid();
    chk("t2_c1_ram_en", 32'(ram_en), 32'd1);
    chk("t2_c1_ram_addr", 32'(ram_addr), 32'd2);
    nxt(); rd_en = 3'b100;
    mid();
    chk("t2_c2_ram_addr", 32'(ram_addr), 32'd3);
    chk("t2_c2_val", 32'(rd_val), 32'b001);
    chk("t2_c2_data", rd_data, 32'd16);
    nxt(); rd_en = 3'b000;
    mid();
    chk("t2_c3_ram_en", 32'(ram_en), 32'd0);
    chk("t2_c3_val", 32'(rd_val), 32'b010);
    chk("t2_c3_data", rd_data, 32'd32);
    nxt();
    mid();
    chk("t2_c4_val", 32'(rd_val), 32'b100);
    chk("t2_c4_data", rd_data, 32'd48);
    nxt();

    // Test 5: client 1 alone (pointer ends at 1), then tie with client 0.
    rd_en = 3'b010; rd_addr = {8'd0, 8'd7, 8'd0};
    mid();
    chk("t5_c0_ram_addr", 32'(ram_addr), 32'd7);
    nxt(); rd_en = 3'b000;
    nxt();
    mid();
    chk("t5_c2_val", 32'(rd_val), 32'b010);
    chk("t5_c2_data", rd_data, 32'd112);
    nxt(); rd_en = 3'b011; rd_addr = {8'd0, 8'd10, 8'd9};
    mid();
    chk("t5_c3_avail", 32'(rd_avail), 32'b111);
    chk("t5_c3_ram_addr", 32'(ram_addr), 32'd9);
    nxt(); rd_en = 3'b010;
    mid();
    chk("t5_c4_ram_en", 32'(ram_en), 32'd1);
    chk("t5_c4_ram_addr", 32'(ram_addr), 32'd10);
    nxt(); rd_en = 3'b000;
    mid();
    chk("t5_c5_val", 32'(rd_val), 32'b001);
    chk("t5_c5_data", rd_data, 32'd144);
    nxt();
    mid();
    chk("t5_c6_val", 32'(rd_val), 32'b010);
    chk("t5_c6_data", rd_data, 32'd160);
    nxt();

    // Test 3: clients 0 and 1 request continuously; pattern grant0, grant1, idle.
    rd_en = 3'b011; rd_addr = {8'd0, 8'd21, 8'd20};
    for (int t = 0; t < 18; t++) begin
      mid();
      chk("t3_ram_en", 32'(ram_en), (t % 3 != 2) ? 32'd1 : 32'd0);
      chk("t3_ram_addr", 32'(ram_addr),
          (t % 3 == 0) ? 32'd20 : (t % 3 == 1) ? 32'd21 : 32'd0);
      chk("t3_val", 32'(rd_val),
          (t % 3 == 2) ? 32'b001 : (t % 3 == 0 && t >= 3) ? 32'b010 : 32'd0);
      nxt();
    end
    rd_en = 3'b000;
    nxt(); nxt(); nxt();

    // Test 4: client 2 granted, reset during flight.
    rd_en = 3'b100; rd_addr = {8'd33, 8'd0, 8'd0};
    mid();
    chk("t4_c0_ram_addr", 32'(ram_addr), 32'd33);
    nxt(); rd_en = 3'b000; rst = 1'b1;
    mid();
    chk("t4_c1_avail", 32'(rd_avail), 32'd0);
    chk("t4_c1_ram_en", 32'(ram_en), 32'd0);
    nxt(); rst = 1'b0;
    mid();
    chk("t4_c2_val", 32'(rd_val), 32'd0);
    chk("t4_c2_avail", 32'(rd_avail), 32'b111);
    nxt(); rd_en = 3'b001; rd_addr = {8'd0, 8'd0, 8'd4};
    mid();
    chk("t4_c3_val", 32'(rd_val), 32'd0);
    chk("t4_c3_ram_addr", 32'(ram_addr), 32'd4);
    nxt(); rd_en = 3'b000;
    nxt();
    mid();
    chk("t4_c5_val", 32'(rd_val), 32'b001);
    chk("t4_c5_data", rd_data, 32'd64);
    nxt();

    // Test 6: latency-1 instance, client 0 holds a request at address 5.
    rd_en2 = 3'b001; rd_addr2 = {8'd0, 8'd0, 8'd5};
    mid();
    chk("t6_c0_ram_en", 32'(ram_en2), 32'd1);
    chk("t6_c0_ram_addr", 32'(ram_addr2), 32'd5);
    nxt();
    mid();
    chk("t6_c1_val", 32'(rd_val2), 32'b001);
    chk("t6_c1_data", rd_data2, 32'd80);
    chk("t6_c1_ram_en", 32'(ram_en2), 32'd0);
    nxt();
    mid();
    chk("t6_c2_ram_en", 32'(ram_en2), 32'd1);
    chk("t6_c2_val", 32'(rd_val2), 32'd0);
    nxt();
    mid();
    chk("t6_c3_val", 32'(rd_val2), 32'b001);
    chk("t6_c3_ram_en", 32'(ram_en2), 32'd0);
    nxt();
    mid();
    chk("t6_c4_ram_en", 32'(ram_en2), 32'd1);
    nxt(); rd_en2 = 3'b000;
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
